// File: rtl/iq_capture_buf.sv
// rtl/iq_capture_buf.sv - three-channel I/Q snapshot buffer with local-bus access
// Optional decimation of captured strobes is enabled by defining IQ_CAPTURE_DECIM_EN.
`timescale 1ns/1ps

module iq_capture_buf #(
  parameter int aw = 8,
  parameter int dw = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic signed [dw-1:0] cav_i,
  input  logic signed [dw-1:0] cav_q,
  input  logic signed [dw-1:0] fwd_i,
  input  logic signed [dw-1:0] fwd_q,
  input  logic signed [dw-1:0] rfl_i,
  input  logic signed [dw-1:0] rfl_q,
  input  logic [14:0]          lb_addr,
  input  logic [31:0]          lb_data,
  input  logic                 lb_write,
  input  logic                 lb_read,
  output logic [31:0]          lb_rdata,
  output logic                 lb_rvalid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  localparam int depth = 2 ** aw;

  state_t              state, state_nxt;
  logic [aw:0]         count;
  logic [1:0]          chan_sel;
  logic [2*dw-1:0]     mem [depth];

  logic                is_reg;
  logic [13:0]         reg_idx;
  logic                ctrl_wr;
  logic                abort_req;
  logic                arm_req;
  logic                take;
  logic                capture;
  logic signed [dw-1:0] sel_i, sel_q;
  logic [2*dw-1:0]     entry;
  logic signed [dw-1:0] half;
  logic [31:0]         rd_word;
  logic                unused_ok;

  assign is_reg    = !lb_addr[14];
  assign reg_idx   = lb_addr[13:0];
  assign ctrl_wr   = lb_write && is_reg && (reg_idx == 14'd0);
  assign abort_req = ctrl_wr && lb_data[1];
  assign arm_req   = ctrl_wr && lb_data[0] && !lb_data[1];
  assign unused_ok = ^lb_data;

`ifdef IQ_CAPTURE_DECIM_EN
  logic [7:0] decim, dec_cnt;

  assign take = (dec_cnt == 8'd0);

  // Reloading to zero on arm makes the first strobe after arm a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decim   <= 8'd0;
      dec_cnt <= 8'd0;
    end else begin
      if (lb_write && is_reg && reg_idx == 14'd2) decim <= lb_data[7:0];
      if (arm_req) dec_cnt <= 8'd0;
      else if (state == FILL && sample && !abort_req)
        dec_cnt <= (dec_cnt == 8'd0) ? decim : dec_cnt - 8'd1;
    end
  end
`else
  assign take = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (abort_req) begin
      state_nxt = IDLE;
    end else if (arm_req) begin
      state_nxt = FILL;
    end else if (state == FILL && sample && take) begin
      capture = 1'b1;
      if (count == (aw+1)'(depth - 1)) state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      chan_sel <= 2'd0;
    end else begin
      state <= state_nxt;
      if (arm_req) count <= '0;
      else if (capture) count <= count + (aw+1)'(1);
      if (lb_write && is_reg && reg_idx == 14'd1) chan_sel <= lb_data[1:0];
    end
  end

  always_comb begin
    sel_i = cav_i;
    sel_q = cav_q;
    case (chan_sel)
      2'd1: begin sel_i = fwd_i; sel_q = fwd_q; end
      2'd2: begin sel_i = rfl_i; sel_q = rfl_q; end
      default: ;
    endcase
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (capture) mem[count[aw-1:0]] <= {sel_i, sel_q};
  end

  always_comb begin
    rd_word = 32'd0;
    entry   = mem[lb_addr[aw:1]];
    half    = lb_addr[0] ? entry[dw-1:0] : entry[2*dw-1:dw];
    if (!is_reg) begin
      rd_word = 32'(half);
    end else begin
      case (reg_idx)
        14'd1: rd_word = {30'd0, chan_sel};
`ifdef IQ_CAPTURE_DECIM_EN
        14'd2: rd_word = {24'd0, decim};
`endif
        14'd3: rd_word = {14'd0, state, 16'(count)};
        default: rd_word = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_rdata  <= 32'd0;
      lb_rvalid <= 1'b0;
    end else begin
      lb_rvalid <= lb_read;
      if (lb_read) lb_rdata <= rd_word;
    end
  end

  assign busy = (state == FILL);
  assign done = (state == DONE);

endmodule

// File: doc/iq_capture_buf.md
IQ_CAPTURE_BUF -- requirements
Module: iq_capture_buf

Interface
REQ-001 SHALL have parameter aw, default 8, giving buffer depth 2^aw samples.
REQ-002 SHALL have parameter dw, default 18, giving signed I/Q sample width.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample  input  1  one-cycle strobe marking valid CIC outputs.
REQ-006 SHALL have ports cav_i, cav_q, fwd_i, fwd_q, rfl_i, rfl_q  input  dw each  signed CIC I/Q outputs for three channels.
REQ-007 SHALL have ports lb_addr  input  15, lb_data  input  32, lb_write  input  1, lb_read  input  1  local bus.
REQ-008 SHALL have port lb_rdata  output  32  registered read data.
REQ-009 SHALL have port lb_rvalid  output  1  high the cycle lb_rdata is valid.
REQ-010 SHALL have ports busy  output  1 (state FILL) and done  output  1 (state DONE).

Function
REQ-011 SHALL implement states IDLE=0, FILL=1, DONE=2; encoding visible in status.
REQ-012 Register map (lb_addr[14]=0): 0 control (write: bit0 arm, bit1 abort); 1 chan_sel[1:0] (0 cav, 1 fwd, 2 rfl, 3 treated as 0); 2 decim[7:0]; 3 status (read only).
REQ-013 Arm in IDLE or DONE SHALL enter FILL, clear write pointer and count; arm in FILL SHALL restart the same way.
REQ-014 Abort SHALL force IDLE from any state, count retained; arm and abort in same write: abort wins.
REQ-015 In FILL, each captured strobe SHALL write {I,Q} of the selected channel at pointer, then increment pointer and count.
REQ-016 Sample strobe in the cycle of the arm write SHALL NOT be captured.
REQ-017 After write at pointer 2^aw-1, state SHALL become DONE next cycle; no further writes; pointer does not wrap.
REQ-018 chan_sel changes SHALL take effect at the next captured strobe, no restart.
REQ-019 Status SHALL read {14'b0, state[1:0], count[15:0]}; count range 0..2^aw.
REQ-020 Buffer read (lb_addr[14]=1): index = lb_addr[aw:1], lb_addr[0]=0 gives I, 1 gives Q, sign-extended to 32 bits.
REQ-021 lb_rdata/lb_rvalid SHALL appear exactly one cycle after lb_read, for registers and buffer alike; unmapped addresses read 0.
REQ-022 Buffer reads during FILL SHALL return current memory contents (no stall, no coherence guarantee).
REQ-023 lb_read and lb_write in same cycle SHALL both be serviced.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, pointer 0, count 0, chan_sel 0, decim 0, lb_rdata 0, lb_rvalid 0, busy 0, done 0.
REQ-025 Buffer memory contents SHALL NOT be reset; rst mid-FILL abandons capture.

Configuration
REQ-026 Macro IQ_CAPTURE_DECIM_EN: defined, a decimation counter captures one strobe of every decim+1, counter reloaded on arm so the first strobe after arm is captured.
REQ-027 Without IQ_CAPTURE_DECIM_EN every strobe in FILL is captured; address 2 reads 0 and writes are ignored.

Verification
REQ-028 aw=4, arm, chan_sel=1, 16 strobes with fwd_i=k, fwd_q=-k -> done=1, status 0x00020010, buffer addr 0x4009 reads 0xFFFFFFFC.
REQ-029 Arm, 5 strobes, abort -> status 0x00000005, busy=0; further strobes leave count 5.
REQ-030 Arm write coincident with strobe, then 3 strobes -> count 3, entry 0 holds second strobe's data.
REQ-031 With IQ_CAPTURE_DECIM_EN, decim=2, 12 strobes -> count 4, entries from strobes 1,4,7,10.
REQ-032 rst asserted mid-FILL at count 7 -> immediately state IDLE, count 0, lb_rvalid 0; re-arm fills normally.
REQ-033 lb_read to address 3 -> lb_rvalid high exactly one cycle later for one cycle; cav_i=-131072 captured reads 0xFFFE0000.
